// File: rtl/mips_register_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port from ALU and mul/div producers.
// Optional synchronous flush port is enabled by defining MIPS_REGISTER_WBQ_FLUSH_EN.
module mips_register_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_L = 32,
    parameter int ADDR_W = $clog2(ADDR_L),
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              resetN,
`ifdef MIPS_REGISTER_WBQ_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    input  logic              mulValid,
    output logic              mulReady,
    input  logic [ADDR_W-1:0] mulAddr,
    input  logic [DATA_W-1:0] mulData,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              wrEnable,
    input  logic              wrReady,
    output logic [ADDR_L-1:0] pending,
    input  logic [ADDR_W-1:0] qAddr,
    output logic              qHit,
    output logic [DATA_W-1:0] qData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic              flush_now;
    logic              full;
    logic              alu_hs;
    logic              mul_hs;
    logic              store;
    logic              deq;
    logic [ADDR_W-1:0] enq_addr;
    logic [DATA_W-1:0] enq_data;

`ifdef MIPS_REGISTER_WBQ_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign full     = (count == CW'(DEPTH));
    assign aluReady = !full && !flush_now;
    assign mulReady = !full && !aluValid && !flush_now;
    assign alu_hs   = aluValid && aluReady;
    assign mul_hs   = mulValid && mulReady;
    assign enq_addr = alu_hs ? aluAddr : mulAddr;
    assign enq_data = alu_hs ? aluData : mulData;
    // r0 is hardwired zero: accept the result but never store it.
    assign store    = (alu_hs || mul_hs) && (enq_addr != '0);

    assign wrEnable = (count != '0);
    assign deq      = wrEnable && wrReady;
    assign wrAddr   = wrEnable ? mem_addr[head] : '0;
    assign wrData   = wrEnable ? mem_data[head] : '0;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else if (flush_now) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_valid <= '0;
        end else begin
            if (deq) begin
                mem_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (store) begin
                mem_addr[tail]  <= enq_addr;
                mem_data[tail]  <= enq_data;
                mem_valid[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end
            count <= count + CW'(store) - CW'(deq);
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_valid[i]) pending[mem_addr[i]] = 1'b1;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        qHit  = 1'b0;
        qData = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem_valid[head + PW'(k)] && (mem_addr[head + PW'(k)] == qAddr) && (qAddr != '0)) begin
                qHit  = 1'b1;
                qData = mem_data[head + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_mips_register_writeback_queue.sv
// Randomized bench for mips_register_writeback_queue against a queue-based reference model.
module tb_mips_register_writeback_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_L = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clock;
    logic              resetN;
    logic              flush;
    logic              aluValid, mulValid, wrReady;
    logic [ADDR_W-1:0] aluAddr, mulAddr, qAddr;
    logic [DATA_W-1:0] aluData, mulData;
    logic              aluReady, mulReady, wrEnable, qHit;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData, qData;
    logic [ADDR_L-1:0] pending;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    mips_register_writeback_queue #(
        .DATA_W(DATA_W), .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .resetN(resetN),
`ifdef MIPS_REGISTER_WBQ_FLUSH_EN
        .flush(flush),
`endif
        .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
        .mulValid(mulValid), .mulReady(mulReady), .mulAddr(mulAddr), .mulData(mulData),
        .wrAddr(wrAddr), .wrData(wrData), .wrEnable(wrEnable), .wrReady(wrReady),
        .pending(pending), .qAddr(qAddr), .qHit(qHit), .qData(qData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against model, advance model at posedge.
    task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                        input logic wr, input logic [ADDR_W-1:0] qa, input logic fl);
        int sz;
        logic e_flush, e_ar, e_mr, e_we, e_hit;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd, e_qd;
        logic [ADDR_L-1:0] e_pend;
        logic [ADDR_W+DATA_W-1:0] ent;
        aluValid = av; aluAddr = aa; aluData = ad;
        mulValid = mv; mulAddr = ma; mulData = md;
        wrReady = wr; qAddr = qa; flush = fl;
        #1;
        sz = exp_q.size();
`ifdef MIPS_REGISTER_WBQ_FLUSH_EN
        e_flush = fl;
`else
        e_flush = 1'b0;
`endif
        e_ar = (sz < DEPTH) && !e_flush;
        e_mr = e_ar && !av;
        e_we = (sz != 0);
        e_wa = '0; e_wd = '0;
        if (e_we) begin
            ent  = exp_q[0];
            e_wa = ent[ADDR_W+DATA_W-1:DATA_W];
            e_wd = ent[DATA_W-1:0];
        end
        e_pend = '0; e_hit = 1'b0; e_qd = '0;
        for (int i = 0; i < sz; i++) begin
            ent = exp_q[i];
            e_pend[ent[ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
            if (qa != 0 && ent[ADDR_W+DATA_W-1:DATA_W] == qa) begin
                e_hit = 1'b1;
                e_qd  = ent[DATA_W-1:0];
            end
        end
        check("aluReady", 64'(aluReady), 64'(e_ar));
        check("mulReady", 64'(mulReady), 64'(e_mr));
        check("wrEnable", 64'(wrEnable), 64'(e_we));
        check("wrAddr", 64'(wrAddr), 64'(e_wa));
        check("wrData", 64'(wrData), 64'(e_wd));
        check("pending", 64'(pending), 64'(e_pend));
        check("qHit", 64'(qHit), 64'(e_hit));
        check("qData", 64'(qData), 64'(e_qd));
        @(posedge clock);
        if (e_flush) begin
            exp_q.delete();
        end else begin
            if (e_we && wr) void'(exp_q.pop_front());
            if (av && e_ar) begin
                if (aa != 0) exp_q.push_back({aa, ad});
            end else if (mv && e_mr) begin
                if (ma != 0) exp_q.push_back({ma, md});
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic wr, input logic [ADDR_W-1:0] qa);
        step(1'b0, '0, '0, 1'b0, '0, '0, wr, qa, 1'b0);
    endtask

    task automatic alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic wr,
                       input logic [ADDR_W-1:0] qa);
        step(1'b1, a, d, 1'b0, '0, '0, wr, qa, 1'b0);
    endtask

    initial begin
        resetN = 1'b0; flush = 1'b0;
        aluValid = 1'b0; aluAddr = '0; aluData = '0;
        mulValid = 1'b0; mulAddr = '0; mulData = '0;
        wrReady = 1'b0; qAddr = '0;
        @(negedge clock);
        check("rst_wrEnable", 64'(wrEnable), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_qHit", 64'(qHit), 64'd0);
        check("rst_wrAddr", 64'(wrAddr), 64'd0);
        check("rst_wrData", 64'(wrData), 64'd0);
        @(negedge clock);
        resetN = 1'b1;

        // Order: two writes to r5 leave in acceptance order.
        alu(5'd5, 32'h11, 1'b1, 5'd5);
        alu(5'd5, 32'h22, 1'b1, 5'd5);
        idle(1'b1, 5'd5);
        idle(1'b1, 5'd0);

        // Priority: ALU wins, mul/div accepted next cycle.
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0);
        idle(1'b1, 5'd3);
        idle(1'b1, 5'd4);

        // Full and wrap.
        for (int i = 1; i <= 4; i++) alu(ADDR_W'(i + 8), DATA_W'(32'h100 + i), 1'b0, 5'd9);
        alu(5'd20, 32'h200, 1'b0, 5'd20);
        alu(5'd20, 32'h200, 1'b1, 5'd20);
        alu(5'd20, 32'h200, 1'b1, 5'd20);
        for (int i = 0; i < 6; i++) idle(1'b1, 5'd20);

        // Forward and pending, including an r0 offer.
        alu(5'd7, 32'hA, 1'b0, 5'd7);
        alu(5'd7, 32'hB, 1'b0, 5'd7);
        idle(1'b0, 5'd7);
        alu(5'd0, 32'hDEAD, 1'b0, 5'd7);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 1'b0);
        idle(1'b0, 5'd7);
        for (int i = 0; i < 4; i++) idle(1'b1, 5'd7);

        // Reset mid-run with three entries queued.
        alu(5'd12, 32'h12, 1'b0, 5'd12);
        alu(5'd13, 32'h13, 1'b0, 5'd13);
        alu(5'd14, 32'h14, 1'b0, 5'd14);
        qAddr = 5'd13;
        resetN = 1'b0;
        #1;
        check("midrst_wrEnable", 64'(wrEnable), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        check("midrst_qHit", 64'(qHit), 64'd0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b1, 5'd13);

`ifdef MIPS_REGISTER_WBQ_FLUSH_EN
        alu(5'd8, 32'h8, 1'b0, 5'd8);
        alu(5'd9, 32'h9, 1'b0, 5'd8);
        step(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1);
        idle(1'b1, 5'd8);
`endif

        // Randomized traffic with a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), ADDR_W'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 50), ADDR_W'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 65), ADDR_W'($urandom_range(0, 7)), 1'b0);
        end
        for (int i = 0; i < 6; i++) idle(1'b1, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
